bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin_if.sv | 23 ++
 rtl/bcd_to_bin.sv | 123 ++++++++++++
 tb/tb_bcd_to_bin.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle for the bcd_to_bin converter: load strobe and digits in,
// binary result with ready/error status out.
`timescale 1ns/1ps
interface bcd_to_bin_if;
  logic        load;
  logic [3:0]  dig_1;
  logic [3:0]  dig_2;
  logic [3:0]  dig_3;
  logic [3:0]  dig_4;
  logic [15:0] number;
  logic        ready;
  logic        error;

  modport master (
    output load, dig_1, dig_2, dig_3, dig_4,
    input  number, ready, error
  );

  modport slave (
    input  load, dig_1, dig_2, dig_3, dig_4,
    output number, ready, error
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative 4-digit BCD-to-binary converter (acc*10 + digit, MSD first, 4 cycles).
// Optional invalid-digit checking is enabled by defining BCD_TO_BIN_CHECK_EN.
`timescale 1ns/1ps
module bcd_to_bin (
  input  logic          clk,
  input  logic          reset,
  bcd_to_bin_if.slave   bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned STEP_W = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]        state,    state_nx;
  logic [DATA_W-1:0] shadow,   shadow_nx;
  logic [DATA_W-1:0] acc,      acc_nx;
  logic [STEP_W-1:0] step,     step_nx;
  logic [DATA_W-1:0] number_q, number_nx;
  logic              ready_q,  ready_nx;
  logic [3:0]        digit_c;
  logic [DATA_W-1:0] acc_step_c;

`ifdef BCD_TO_BIN_CHECK_EN
  logic flag,    flag_nx;
  logic error_q, error_nx;
`endif

  // Current digit, thousands first
  always_comb begin
    digit_c = shadow[3:0];
    case (step)
      2'd0:    digit_c = shadow[15:12];
      2'd1:    digit_c = shadow[11:8];
      2'd2:    digit_c = shadow[7:4];
      default: digit_c = shadow[3:0];
    endcase
  end

  // acc*10 + digit using shifts and adds only
  assign acc_step_c = DATA_W'(acc << 3) + DATA_W'(acc << 1) + DATA_W'(digit_c);

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    acc_nx    = acc;
    step_nx   = step;
    number_nx = number_q;
    ready_nx  = ready_q;
`ifdef BCD_TO_BIN_CHECK_EN
    flag_nx   = flag;
    error_nx  = error_q;
`endif
    case (state)
      IDLE: begin
        if (bus.load) begin
          shadow_nx = {bus.dig_4, bus.dig_3, bus.dig_2, bus.dig_1};
          acc_nx    = '0;
          step_nx   = '0;
          ready_nx  = 1'b0;
          state_nx  = CONV;
`ifdef BCD_TO_BIN_CHECK_EN
          flag_nx   = 1'b0;
`endif
        end
      end
      CONV: begin
        acc_nx  = acc_step_c;
        step_nx = step + STEP_W'(1);
`ifdef BCD_TO_BIN_CHECK_EN
        flag_nx = flag | (digit_c > 4'd9);
`endif
        if (step == STEP_W'(3)) begin
          state_nx  = IDLE;
          ready_nx  = 1'b1;
`ifdef BCD_TO_BIN_CHECK_EN
          error_nx  = flag_nx;
          number_nx = flag_nx ? '0 : acc_step_c;
`else
          number_nx = acc_step_c;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shadow   <= '0;
      acc      <= '0;
      step     <= '0;
      number_q <= '0;
      ready_q  <= 1'b1;
`ifdef BCD_TO_BIN_CHECK_EN
      flag     <= 1'b0;
      error_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      shadow   <= shadow_nx;
      acc      <= acc_nx;
      step     <= step_nx;
      number_q <= number_nx;
      ready_q  <= ready_nx;
`ifdef BCD_TO_BIN_CHECK_EN
      flag     <= flag_nx;
      error_q  <= error_nx;
`endif
    end
  end

  assign bus.number = number_q;
  assign bus.ready  = ready_q;
`ifdef BCD_TO_BIN_CHECK_EN
  assign bus.error  = error_q;
`else
  assign bus.error  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized
// conversions compared against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_to_bin;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  bcd_to_bin_if ifc ();

  bcd_to_bin u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: positional decimal value; invalid digits zero the result when checking is on
  function automatic void model(input int d4, input int d3, input int d2, input int d1,
                                output int num, output int err);
    int  raw;
    bit  bad;
    raw = d4 * 1000 + d3 * 100 + d2 * 10 + d1;
    bad = (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9);
`ifdef BCD_TO_BIN_CHECK_EN
    err = bad ? 1 : 0;
    num = bad ? 0 : raw;
`else
    err = 0;
    num = raw;
`endif
  endfunction

  task automatic drive(input int d4, input int d3, input int d2, input int d1, input logic ld);
    ifc.dig_4 = 4'(d4);
    ifc.dig_3 = 4'(d3);
    ifc.dig_2 = 4'(d2);
    ifc.dig_1 = 4'(d1);
    ifc.load  = ld;
  endtask

  // Full conversion: load at one edge, scramble inputs, wait for ready, check everything
  task automatic convert(input string tag, input int d4, input int d3, input int d2, input int d1);
    int lat;
    int enum_v, eerr;
    logic [15:0] prev;
    model(d4, d3, d2, d1, enum_v, eerr);
    @(negedge clk);
    prev = ifc.number;
    drive(d4, d3, d2, d1, 1'b1);
    @(negedge clk);
    drive(int'($urandom_range(15)), int'($urandom_range(15)),
          int'($urandom_range(15)), int'($urandom_range(15)), 1'b0);
    lat = 0;
    while (ifc.ready !== 1'b1 && lat < 20) begin
      if (ifc.number !== prev) chk({tag, "_hold"}, 32'(ifc.number), 32'(prev));
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_num"}, 32'(ifc.number), 32'(enum_v));
    chk({tag, "_err"}, 32'(ifc.error), 32'(eerr));
  endtask

  initial begin
    int en, ee;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ifc.ready), 32'd1);
    chk("rst_num", 32'(ifc.number), 32'd0);
    chk("rst_err", 32'(ifc.error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    convert("c97", 0, 0, 9, 7);
    convert("c0", 0, 0, 0, 0);
    convert("c9999", 9, 9, 9, 9);

    // Loads at N+2 and N+4 ignored; N+5 accepted
    @(negedge clk);
    drive(9, 9, 9, 8, 1'b1);          // edge N
    @(negedge clk);
    drive(0, 0, 0, 0, 1'b0);          // edge N+1
    chk("ign_busy", 32'(ifc.ready), 32'd0);
    @(negedge clk);
    drive(1, 2, 3, 4, 1'b1);          // edge N+2
    @(negedge clk);
    drive(1, 2, 3, 4, 1'b0);          // edge N+3
    @(negedge clk);
    drive(1, 2, 3, 4, 1'b1);          // edge N+4
    @(negedge clk);
    chk("ign_ready", 32'(ifc.ready), 32'd1);
    chk("ign_num", 32'(ifc.number), 32'd9998);
    @(negedge clk);                   // edge N+5 accepted
    drive(0, 0, 0, 0, 1'b0);
    chk("b2b_busy", 32'(ifc.ready), 32'd0);
    chk("b2b_hold", 32'(ifc.number), 32'd9998);
    repeat (3) @(negedge clk);
    chk("b2b_busy3", 32'(ifc.ready), 32'd0);
    @(negedge clk);                   // after edge N+9
    chk("b2b_ready", 32'(ifc.ready), 32'd1);
    chk("b2b_num", 32'(ifc.number), 32'd1234);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    drive(5, 0, 0, 0, 1'b1);
    @(negedge clk);
    drive(5, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_ready", 32'(ifc.ready), 32'd1);
    chk("arst_num", 32'(ifc.number), 32'd0);
    chk("arst_err", 32'(ifc.error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    convert("c42", 0, 0, 4, 2);

    // Invalid digit, then a valid one clears the status
    convert("bad15", 0, 0, 1, 15);
    convert("c3", 0, 0, 0, 3);
    convert("badall", 15, 10, 12, 11);
    convert("c1", 0, 0, 0, 1);

    // Randomized valid values through decimal split
    for (int i = 0; i < 300; i++) begin
      int v;
      v = int'($urandom_range(9999));
      convert("rnd", v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10);
    end
    // Randomized raw nibbles, including invalid digits
    for (int i = 0; i < 100; i++) begin
      convert("rawrnd", int'($urandom_range(15)), int'($urandom_range(15)),
              int'($urandom_range(15)), int'($urandom_range(15)));
    end

    // Continuous load: a new result every 5 cycles
    @(negedge clk);
    drive(0, 8, 7, 6, 1'b1);
    repeat (5) @(negedge clk);
    model(0, 8, 7, 6, en, ee);
    chk("cont_num1", 32'(ifc.number), 32'(en));
    drive(3, 2, 1, 0, 1'b1);          // captured at the edge just after this
    repeat (5) @(negedge clk);
    chk("cont_num2", 32'(ifc.number), 32'd3210);
    drive(0, 0, 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("cont_idle", 32'(ifc.ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
